// File: rtl/mgc_ace_snoop_tracker.sv
// Passive tracker for the ACE snoop channels (AC/CR/CD) of one master port: queues snoop
// addresses, pairs them with CR responses, counts owed CD bursts and flags protocol errors.
module mgc_ace_snoop_tracker #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned SDATA_WIDTH = 64,
    parameter int unsigned LINE_WIDTH  = 512,
    parameter int unsigned DEPTH       = 4,
    localparam int unsigned CNTW       = $clog2(DEPTH + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  ACVALID,
    input  logic                  ACREADY,
    input  logic [ADDR_WIDTH-1:0] ACADDR,
    input  logic [3:0]            ACSNOOP,
    input  logic [2:0]            ACPROT,
    input  logic                  CRVALID,
    input  logic                  CRREADY,
    input  logic [4:0]            CRRESP,
    input  logic                  CDVALID,
    input  logic                  CDREADY,
    input  logic                  CDLAST,
    output logic [CNTW-1:0]       outstanding,
    output logic [CNTW-1:0]       data_owed,
    output logic                  done_valid,
    output logic [ADDR_WIDTH-1:0] done_addr,
    output logic [3:0]            done_snoop,
    output logic [4:0]            done_resp,
    output logic                  err_ac_ovf,
    output logic                  err_ac_unstab,
    output logic                  err_cr_orph,
    output logic                  err_cd_orph,
    output logic                  err_cdlast
);

    localparam int unsigned BEATS = LINE_WIDTH / SDATA_WIDTH;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam logic [CNTW-1:0] DepthC    = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] OwedMax   = '1;
    localparam logic [BW-1:0]   LastBeat  = BW'(BEATS - 1);

    typedef enum logic {CdIdle, CdBurst} cd_state_e;

    logic ac_hs, cr_hs, cd_hs, full, empty, push, pop;
    logic owed_inc, cd_done, cd_take, cd_exp_last;

    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [3:0]            mem_snoop [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]       cnt_q, cnt_d, owed_q, owed_d;
    logic [BW-1:0]         beat_q, beat_d;
    cd_state_e             cd_state_q, cd_state_d;

    logic                  ac_wait_q, ac_wait_d;
    logic [ADDR_WIDTH-1:0] ac_addr_prev_q, ac_addr_prev_d;
    logic [3:0]            ac_snoop_prev_q, ac_snoop_prev_d;
    logic [2:0]            ac_prot_prev_q, ac_prot_prev_d;

    logic                  done_valid_q, done_valid_d;
    logic [ADDR_WIDTH-1:0] done_addr_q, done_addr_d;
    logic [3:0]            done_snoop_q, done_snoop_d;
    logic [4:0]            done_resp_q, done_resp_d;
    logic                  err_ac_ovf_q, err_ac_ovf_d;
    logic                  err_ac_unstab_q, err_ac_unstab_d;
    logic                  err_cr_orph_q, err_cr_orph_d;
    logic                  err_cd_orph_q, err_cd_orph_d;
    logic                  err_cdlast_q, err_cdlast_d;

    assign ac_hs = ACVALID & ACREADY;
    assign cr_hs = CRVALID & CRREADY;
    assign cd_hs = CDVALID & CDREADY;
    assign full  = (cnt_q == DepthC);
    assign empty = (cnt_q == '0);
    // A full FIFO drops the AC even when a pop happens in the same cycle.
    assign push  = ac_hs & ~full;
    assign pop   = cr_hs & ~empty;

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_addr[wr_ptr_q]  <= ACADDR;
            mem_snoop[wr_ptr_q] <= ACSNOOP;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end

        done_valid_d = pop;
        done_addr_d  = done_addr_q;
        done_snoop_d = done_snoop_q;
        done_resp_d  = done_resp_q;
        if (pop) begin
            done_addr_d  = mem_addr[rd_ptr_q];
            done_snoop_d = mem_snoop[rd_ptr_q];
            done_resp_d  = CRRESP;
        end

        ac_wait_d       = ACVALID & ~ACREADY;
        ac_addr_prev_d  = ACADDR;
        ac_snoop_prev_d = ACSNOOP;
        ac_prot_prev_d  = ACPROT;
        err_ac_unstab_d = ac_wait_q & ACVALID &
                          ((ACADDR != ac_addr_prev_q) | (ACSNOOP != ac_snoop_prev_q) |
                           (ACPROT != ac_prot_prev_q));
        err_ac_ovf_d    = ac_hs & full;
        err_cr_orph_d   = cr_hs & empty;
    end

    // beat_q is 0 in CdIdle, so the same last-beat compare covers BEATS==1.
    always_comb begin
        cd_state_d    = cd_state_q;
        beat_d        = beat_q;
        cd_done       = 1'b0;
        err_cdlast_d  = 1'b0;
        err_cd_orph_d = 1'b0;
        cd_take       = cd_hs & ((cd_state_q == CdBurst) | (owed_q != '0));
        cd_exp_last   = (beat_q == LastBeat);
        if (cd_take) begin
            err_cdlast_d = (CDLAST != cd_exp_last);
            if (cd_exp_last) begin
                beat_d     = '0;
                cd_state_d = CdIdle;
                cd_done    = 1'b1;
            end else begin
                beat_d     = beat_q + 1'b1;
                cd_state_d = CdBurst;
            end
        end else if (cd_hs) begin
            err_cd_orph_d = 1'b1;
        end

        owed_inc = pop & CRRESP[0];
        owed_d   = owed_q;
        if (owed_inc && !cd_done) begin
            owed_d = (owed_q == OwedMax) ? owed_q : owed_q + 1'b1;
        end else if (cd_done && !owed_inc) begin
            owed_d = owed_q - 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cnt_q           <= '0;
            owed_q          <= '0;
            beat_q          <= '0;
            cd_state_q      <= CdIdle;
            ac_wait_q       <= 1'b0;
            ac_addr_prev_q  <= '0;
            ac_snoop_prev_q <= '0;
            ac_prot_prev_q  <= '0;
            done_valid_q    <= 1'b0;
            done_addr_q     <= '0;
            done_snoop_q    <= '0;
            done_resp_q     <= '0;
            err_ac_ovf_q    <= 1'b0;
            err_ac_unstab_q <= 1'b0;
            err_cr_orph_q   <= 1'b0;
            err_cd_orph_q   <= 1'b0;
            err_cdlast_q    <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            cnt_q           <= cnt_d;
            owed_q          <= owed_d;
            beat_q          <= beat_d;
            cd_state_q      <= cd_state_d;
            ac_wait_q       <= ac_wait_d;
            ac_addr_prev_q  <= ac_addr_prev_d;
            ac_snoop_prev_q <= ac_snoop_prev_d;
            ac_prot_prev_q  <= ac_prot_prev_d;
            done_valid_q    <= done_valid_d;
            done_addr_q     <= done_addr_d;
            done_snoop_q    <= done_snoop_d;
            done_resp_q     <= done_resp_d;
            err_ac_ovf_q    <= err_ac_ovf_d;
            err_ac_unstab_q <= err_ac_unstab_d;
            err_cr_orph_q   <= err_cr_orph_d;
            err_cd_orph_q   <= err_cd_orph_d;
            err_cdlast_q    <= err_cdlast_d;
        end
    end

    assign outstanding   = cnt_q;
    assign data_owed     = owed_q;
    assign done_valid    = done_valid_q;
    assign done_addr     = done_addr_q;
    assign done_snoop    = done_snoop_q;
    assign done_resp     = done_resp_q;
    assign err_ac_ovf    = err_ac_ovf_q;
    assign err_ac_unstab = err_ac_unstab_q;
    assign err_cr_orph   = err_cr_orph_q;
    assign err_cd_orph   = err_cd_orph_q;
    assign err_cdlast    = err_cdlast_q;

endmodule

// File: tb/tb_mgc_ace_snoop_tracker.sv
// Bench for mgc_ace_snoop_tracker: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_mgc_ace_snoop_tracker;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BEATS = 8;
    localparam int unsigned CNTW  = 3;
    localparam int          OMAX  = 7;

    logic        ACLK, ARESET;
    logic        ACVALID, ACREADY, CRVALID, CRREADY, CDVALID, CDREADY, CDLAST;
    logic [31:0] ACADDR;
    logic [3:0]  ACSNOOP;
    logic [2:0]  ACPROT;
    logic [4:0]  CRRESP;
    logic [CNTW-1:0] outstanding, data_owed;
    logic        done_valid;
    logic [31:0] done_addr;
    logic [3:0]  done_snoop;
    logic [4:0]  done_resp;
    logic        err_ac_ovf, err_ac_unstab, err_cr_orph, err_cd_orph, err_cdlast;

    int n_vec  = 0;
    int n_fail = 0;

    mgc_ace_snoop_tracker #(
        .ADDR_WIDTH(32), .SDATA_WIDTH(64), .LINE_WIDTH(512), .DEPTH(DEPTH)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ACVALID(ACVALID), .ACREADY(ACREADY), .ACADDR(ACADDR), .ACSNOOP(ACSNOOP),
        .ACPROT(ACPROT),
        .CRVALID(CRVALID), .CRREADY(CRREADY), .CRRESP(CRRESP),
        .CDVALID(CDVALID), .CDREADY(CDREADY), .CDLAST(CDLAST),
        .outstanding(outstanding), .data_owed(data_owed),
        .done_valid(done_valid), .done_addr(done_addr), .done_snoop(done_snoop),
        .done_resp(done_resp),
        .err_ac_ovf(err_ac_ovf), .err_ac_unstab(err_ac_unstab), .err_cr_orph(err_cr_orph),
        .err_cd_orph(err_cd_orph), .err_cdlast(err_cdlast)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: snoop queue, owed-burst count, beats seen in current burst.
    logic [31:0] mq_addr [$];
    logic [3:0]  mq_snoop [$];
    int          m_owed, m_beats, m_n, m_inc, m_dec;
    logic        p_wait;
    logic [38:0] p_pay;
    logic        e_dv, e_ovf, e_unst, e_cro, e_cdo, e_cdl;
    logic [31:0] e_da;
    logic [3:0]  e_ds;
    logic [4:0]  e_dr;

    always @(posedge ACLK) begin
        {e_dv, e_ovf, e_unst, e_cro, e_cdo, e_cdl} = '0;
        if (ARESET) begin
            mq_addr.delete();
            mq_snoop.delete();
            m_owed  = 0;
            m_beats = 0;
        end else begin
            m_inc = 0;
            m_dec = 0;
            m_n   = mq_addr.size();
            e_unst = p_wait && ACVALID && ({ACADDR, ACSNOOP, ACPROT} != p_pay);
            if (CRVALID && CRREADY) begin
                if (m_n > 0) begin
                    e_dv  = 1'b1;
                    e_da  = mq_addr.pop_front();
                    e_ds  = mq_snoop.pop_front();
                    e_dr  = CRRESP;
                    m_inc = CRRESP[0] ? 1 : 0;
                end else begin
                    e_cro = 1'b1;
                end
            end
            if (ACVALID && ACREADY) begin
                if (m_n < DEPTH) begin
                    mq_addr.push_back(ACADDR);
                    mq_snoop.push_back(ACSNOOP);
                end else begin
                    e_ovf = 1'b1;
                end
            end
            if (CDVALID && CDREADY) begin
                if (m_beats > 0 || m_owed > 0) begin
                    e_cdl = (CDLAST != (m_beats == BEATS - 1));
                    if (m_beats == BEATS - 1) begin
                        m_beats = 0;
                        m_dec   = 1;
                    end else begin
                        m_beats++;
                    end
                end else begin
                    e_cdo = 1'b1;
                end
            end
            m_owed = m_owed + m_inc - m_dec;
            if (m_owed > OMAX) m_owed = OMAX;
        end
        p_wait = !ARESET && ACVALID && !ACREADY;
        p_pay  = {ACADDR, ACSNOOP, ACPROT};
        #1;
        chk("outstanding", 64'(outstanding), 64'(mq_addr.size()));
        chk("data_owed", 64'(data_owed), 64'(m_owed));
        chk("done_valid", 64'(done_valid), 64'(e_dv));
        if (e_dv) begin
            chk("done_addr", 64'(done_addr), 64'(e_da));
            chk("done_snoop", 64'(done_snoop), 64'(e_ds));
            chk("done_resp", 64'(done_resp), 64'(e_dr));
        end
        chk("err_ac_ovf", 64'(err_ac_ovf), 64'(e_ovf));
        chk("err_ac_unstab", 64'(err_ac_unstab), 64'(e_unst));
        chk("err_cr_orph", 64'(err_cr_orph), 64'(e_cro));
        chk("err_cd_orph", 64'(err_cd_orph), 64'(e_cdo));
        chk("err_cdlast", 64'(err_cdlast), 64'(e_cdl));
    end

    task automatic step();
        @(posedge ACLK);
        #2;
    endtask

    task automatic idle();
        ACVALID = 0; ACREADY = 0; CRVALID = 0; CRREADY = 0;
        CDVALID = 0; CDREADY = 0; CDLAST = 0;
    endtask

    task automatic ac(input logic [31:0] a, input logic [3:0] s);
        ACVALID = 1; ACREADY = 1; ACADDR = a; ACSNOOP = s; ACPROT = 3'd2;
    endtask

    task automatic cr(input logic [4:0] r);
        CRVALID = 1; CRREADY = 1; CRRESP = r;
    endtask

    task automatic cd_burst(input int last_at);
        for (int b = 0; b < BEATS; b++) begin
            CDVALID = 1; CDREADY = 1; CDLAST = (b == last_at);
            step();
            if (last_at != BEATS - 1 && (b == 3 || b == 7))
                chk("lit_cdlast_err", 64'(err_cdlast), 64'd1);
        end
        idle();
    endtask

    initial begin
        ARESET = 1'b1;
        idle();
        ACADDR = '0; ACSNOOP = '0; ACPROT = '0; CRRESP = '0;
        step(); step();
        chk("lit_rst_outstanding", 64'(outstanding), 64'd0);
        chk("lit_rst_owed", 64'(data_owed), 64'd0);
        chk("lit_rst_done", 64'(done_valid), 64'd0);
        ARESET = 1'b0;
        step();

        // Basic AC then CR
        ac(32'h1000, 4'h1); step(); idle();
        chk("lit_out_1", 64'(outstanding), 64'd1);
        cr(5'h00); step(); idle();
        chk("lit_done_valid", 64'(done_valid), 64'd1);
        chk("lit_done_addr", 64'(done_addr), 64'h1000);
        chk("lit_done_resp", 64'(done_resp), 64'h0);
        chk("lit_out_0", 64'(outstanding), 64'd0);
        step();
        chk("lit_done_pulse", 64'(done_valid), 64'd0);

        // Overflow on the fifth AC, then in-order retirement
        for (int i = 0; i < 5; i++) begin
            ac(32'h2000 + 32'(i) * 32'h40, 4'(i)); step();
            if (i == 3) chk("lit_no_ovf", 64'(err_ac_ovf), 64'd0);
        end
        idle();
        chk("lit_ovf", 64'(err_ac_ovf), 64'd1);
        chk("lit_out_full", 64'(outstanding), 64'd4);
        for (int i = 0; i < 4; i++) begin
            cr(5'h04); step();
            chk("lit_order", 64'(done_addr), 64'h2000 + 64'(i) * 64'h40);
        end
        idle(); step();

        // DataTransfer burst with correct and misplaced CDLAST
        ac(32'h3000, 4'h7); step(); idle();
        cr(5'h01); step(); idle();
        chk("lit_owed_1", 64'(data_owed), 64'd1);
        cd_burst(7);
        chk("lit_owed_0", 64'(data_owed), 64'd0);
        ac(32'h3040, 4'h7); step(); idle();
        cr(5'h01); step(); idle();
        cd_burst(3);
        step();

        // Orphans
        cr(5'h01); CDVALID = 1; CDREADY = 1; CDLAST = 1; step(); idle();
        chk("lit_cr_orph", 64'(err_cr_orph), 64'd1);
        chk("lit_cd_orph", 64'(err_cd_orph), 64'd1);
        chk("lit_orph_owed", 64'(data_owed), 64'd0);
        chk("lit_orph_out", 64'(outstanding), 64'd0);

        // Simultaneous push and pop, and no-bypass on empty
        ac(32'h5000, 4'h2); step();
        ac(32'h5040, 4'h3); cr(5'h02); step(); idle();
        chk("lit_pp_out", 64'(outstanding), 64'd1);
        chk("lit_pp_addr", 64'(done_addr), 64'h5000);
        cr(5'h00); step(); idle();
        ac(32'h6000, 4'h4); cr(5'h00); step(); idle();
        chk("lit_nobypass_orph", 64'(err_cr_orph), 64'd1);
        chk("lit_nobypass_out", 64'(outstanding), 64'd1);
        cr(5'h00); step(); idle();
        chk("lit_nobypass_addr", 64'(done_addr), 64'h6000);

        // Unstable AC payload while stalled
        ACVALID = 1; ACREADY = 0; ACADDR = 32'h40; ACSNOOP = 4'h1; ACPROT = 3'd0; step();
        ACADDR = 32'h80; step();
        chk("lit_unstab", 64'(err_ac_unstab), 64'd1);
        ACREADY = 1; step(); idle();
        cr(5'h00); step(); idle();

        // Async reset in the middle of a burst
        ac(32'h7000, 4'h5); step(); idle();
        cr(5'h01); step(); idle();
        for (int b = 0; b < 3; b++) begin
            CDVALID = 1; CDREADY = 1; CDLAST = 0; step();
        end
        idle();
        ARESET = 1'b1;
        #1;
        chk("lit_rst_mid_owed", 64'(data_owed), 64'd0);
        chk("lit_rst_mid_out", 64'(outstanding), 64'd0);
        chk("lit_rst_mid_errs", 64'({err_ac_ovf, err_ac_unstab, err_cr_orph, err_cd_orph,
                                     err_cdlast, done_valid}), 64'd0);
        step();
        ARESET = 1'b0;
        step();
        CDVALID = 1; CDREADY = 1; CDLAST = 0; step(); idle();
        chk("lit_post_rst_orph", 64'(err_cd_orph), 64'd1);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
